// File: rtl/countdown_timer.sv
// Countdown timer: loads a scaled preset code and decrements PresentTime once
// every CLK_DIV enabled cycles, flagging completion with Done/Expired.
module countdown_timer #(
    parameter int unsigned CLK_DIV     = 1000,
    parameter int unsigned PRESET_STEP = 60
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [3:0]  CounterInput,
    input  logic        CounterEnable,
    input  logic        Load,
    output logic [11:0] PresentTime,
    output logic        Busy,
    output logic        Done,
    output logic        Expired
);

    localparam int unsigned TW = 12;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FW = 36;
    localparam logic [TW-1:0] T_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        RUNNING = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   presc, presc_d;
    logic [TW-1:0]   time_d;
    logic            busy_d, done_d, expired_d;
    logic [FW-1:0]   preset_full;
    logic [TW-1:0]   preset;
    logic            tick, terminal;

    // Preset scaling, saturated to the 12-bit range rather than wrapped
    always_comb begin
        preset_full = FW'(CounterInput) * FW'(PRESET_STEP);
        preset      = (preset_full > FW'(T_MAX)) ? T_MAX : preset_full[TW-1:0];
    end

    assign tick     = (state == RUNNING) && CounterEnable && (presc == PW'(CLK_DIV - 1));
    assign terminal = tick && (PresentTime == TW'(1));

    // State and output registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            presc       <= '0;
            PresentTime <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Expired     <= 1'b0;
        end else begin
            state       <= state_d;
            presc       <= presc_d;
            PresentTime <= time_d;
            Busy        <= busy_d;
            Done        <= done_d;
            Expired     <= expired_d;
        end
    end

    // Next-state logic; Load overrides everything else
    always_comb begin
        state_d = state;
        if (Load) begin
            state_d = (preset != '0) ? LOADED : IDLE;
        end else begin
            case (state)
                LOADED, PAUSED: begin
                    if (CounterEnable) state_d = RUNNING;
                end
                RUNNING: begin
                    if (!CounterEnable) state_d = PAUSED;
                    else if (terminal)  state_d = EXPIRED;
                end
                default: state_d = state;
            endcase
        end
    end

    // Datapath and flag next values; the prescaler survives a pause
    always_comb begin
        time_d    = PresentTime;
        presc_d   = presc;
        if (Load) begin
            time_d  = preset;
            presc_d = '0;
        end else if ((state == RUNNING) && CounterEnable) begin
            if (tick) begin
                presc_d = '0;
                if (PresentTime != '0) time_d = PresentTime - TW'(1);
            end else begin
                presc_d = presc + PW'(1);
            end
        end
        busy_d    = (state_d == RUNNING);
        expired_d = (state_d == EXPIRED);
        done_d    = terminal && !Load;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUTs.
module tb_countdown_timer;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  code = 4'd0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic [11:0] pt;
    logic        busy, done, expired;

    logic [3:0]  code2 = 4'd0;
    logic        en2 = 1'b0;
    logic        ld2 = 1'b0;
    logic [11:0] pt2;
    logic        busy2, done2, expired2;

    int unsigned edge_cnt = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;

    typedef struct {
        int unsigned tag;
        bit          dut;
        string       name;
        logic [11:0] t;
        logic        b;
        logic        d;
        logic        e;
    } exp_t;

    exp_t q[$];

    countdown_timer #(.CLK_DIV(4), .PRESET_STEP(60)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .CounterInput(code),
        .CounterEnable(en), .Load(ld), .PresentTime(pt),
        .Busy(busy), .Done(done), .Expired(expired)
    );

    countdown_timer #(.CLK_DIV(4), .PRESET_STEP(300)) dut_sat (
        .Clock(Clock), .Reset_n(Reset_n), .CounterInput(code2),
        .CounterEnable(en2), .Load(ld2), .PresentTime(pt2),
        .Busy(busy2), .Done(done2), .Expired(expired2)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) edge_cnt = edge_cnt + 1;

    // Monitor: compare every expectation whose sampling point has arrived
    always @(negedge Clock) begin
        exp_t        x;
        logic [11:0] at;
        logic        ab, ad, ae;
        while (q.size() > 0 && q[0].tag <= edge_cnt) begin
            x = q.pop_front();
            if (x.dut) begin
                at = pt2; ab = busy2; ad = done2; ae = expired2;
            end else begin
                at = pt;  ab = busy;  ad = done;  ae = expired;
            end
            checks++;
            if (at === x.t && ab === x.b && ad === x.d && ae === x.e)
                passes++;
            else
                $display("FAIL %s: got time=%0d busy=%0b done=%0b expired=%0b, expected time=%0d busy=%0b done=%0b expired=%0b",
                         x.name, at, ab, ad, ae, x.t, x.b, x.d, x.e);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_out(input bit which, input string name, input logic [11:0] t,
                              input logic b, input logic d, input logic e);
        exp_t x;
        x.tag  = edge_cnt;
        x.dut  = which;
        x.name = name;
        x.t    = t;
        x.b    = b;
        x.d    = d;
        x.e    = e;
        q.push_back(x);
    endtask

    task automatic do_load(input logic [3:0] c);
        code = c;
        ld   = 1'b1;
        step();
        ld   = 1'b0;
    endtask

    initial begin
        // Reset state of both instances
        step();
        expect_out(0, "reset", 12'd0, 0, 0, 0);
        expect_out(1, "reset_sat", 12'd0, 0, 0, 0);
        @(negedge Clock);
        #1 Reset_n = 1'b1;

        // Load code 2 -> 120, LOADED holds without enable
        do_load(4'd2);
        expect_out(0, "load_2", 12'd120, 0, 0, 0);
        step();
        expect_out(0, "loaded_hold", 12'd120, 0, 0, 0);

        // Full countdown from 60 at CLK_DIV=4
        do_load(4'd1);
        expect_out(0, "load_1", 12'd60, 0, 0, 0);
        en = 1'b1;
        step();
        expect_out(0, "run_entry", 12'd60, 1, 0, 0);
        for (int i = 1; i < 240; i++) begin
            step();
            expect_out(0, $sformatf("cd_%0d", i), 12'(60 - i / 4), 1, 0, 0);
        end
        step();
        expect_out(0, "terminal", 12'd0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            expect_out(0, $sformatf("expired_hold_%0d", i), 12'd0, 0, 0, 1);
        end
        en = 1'b0;

        // Pause at prescaler 2, resume, next decrement two edges later
        do_load(4'd1);
        expect_out(0, "reload_clears_exp", 12'd60, 0, 0, 0);
        en = 1'b1;
        step(); expect_out(0, "pr_entry", 12'd60, 1, 0, 0);
        step(); step();
        expect_out(0, "pr_presc2", 12'd60, 1, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out(0, $sformatf("paused_%0d", i), 12'd60, 0, 0, 0);
        end
        en = 1'b1;
        step(); expect_out(0, "resume_edge", 12'd60, 1, 0, 0);
        step(); expect_out(0, "resume_p1", 12'd60, 1, 0, 0);
        step(); expect_out(0, "resume_dec", 12'd59, 1, 0, 0);
        en = 1'b0;
        step();

        // Load with enable while running at 100
        do_load(4'd2);
        en = 1'b1;
        step(); expect_out(0, "lp_entry", 12'd120, 1, 0, 0);
        repeat (80) step();
        expect_out(0, "lp_at_100", 12'd100, 1, 0, 0);
        code = 4'd3; ld = 1'b1;
        step(); expect_out(0, "lp_load_wins", 12'd180, 0, 0, 0);
        ld = 1'b0;
        step(); expect_out(0, "lp_rerun", 12'd180, 1, 0, 0);
        en = 1'b0;
        step();

        // Load coinciding with the terminal decrement suppresses Done/Expired
        do_load(4'd1);
        en = 1'b1;
        step();
        repeat (238) step();
        step(); expect_out(0, "lt_at_1", 12'd1, 1, 0, 0);
        code = 4'd1; ld = 1'b1;
        step(); expect_out(0, "lt_load_wins", 12'd60, 0, 0, 0);
        ld = 1'b0;
        step(); expect_out(0, "lt_rerun", 12'd60, 1, 0, 0);
        step(); expect_out(0, "lt_no_done", 12'd60, 1, 0, 0);
        en = 1'b0;
        step();

        // Zero preset goes IDLE and ignores enable
        do_load(4'd0);
        expect_out(0, "zero_load", 12'd0, 0, 0, 0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out(0, $sformatf("zero_idle_%0d", i), 12'd0, 0, 0, 0);
        end
        en = 1'b0;
        do_load(4'd15);
        expect_out(0, "max_code_60", 12'd900, 0, 0, 0);

        // Saturation with PRESET_STEP=300
        code2 = 4'd15; ld2 = 1'b1;
        step(); expect_out(1, "sat_15", 12'd4095, 0, 0, 0);
        code2 = 4'd13;
        step(); expect_out(1, "nosat_13", 12'd3900, 0, 0, 0);
        ld2 = 1'b0;

        // Asynchronous reset mid-run at 57
        do_load(4'd1);
        en = 1'b1;
        step();
        repeat (12) step();
        expect_out(0, "mr_at_57", 12'd57, 1, 0, 0);
        step();
        expect_out(0, "mr_57_p1", 12'd57, 1, 0, 0);
        step();
        Reset_n = 1'b0;
        expect_out(0, "async_reset", 12'd0, 0, 0, 0);
        expect_out(1, "async_reset_sat", 12'd0, 0, 0, 0);
        step();
        step();
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out(0, $sformatf("post_reset_idle_%0d", i), 12'd0, 0, 0, 0);
        end
        en = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clock);
        #1;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expectations, expected 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown timer stage that sits directly downstream of the mode `Controller`. It consumes the controller's `CounterInput` preset code and `CounterEnable` gate, and turns them into a decrementing 12-bit `PresentTime`. That value feeds back to the controller and to the display, with completion flags. Time advances one unit every `CLK_DIV` enabled clock cycles.

## Interface
- `CLK_DIV`, default 1000: clock cycles per time unit (≥1).
- `PRESET_STEP`, default 60: time units per `CounterInput` code step.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `CounterInput`  in  4  preset code from the controller, sampled only when `Load`=1.
- `CounterEnable`  in  1  count gate from the controller; level-sensitive.
- `Load`  in  1  synchronous load strobe; highest synchronous priority.
- `PresentTime`  out  12  remaining time, registered.
- `Busy`  out  1  high while state is RUNNING, registered.
- `Done`  out  1  one-cycle pulse on the edge where `PresentTime` reaches 0 by counting.
- `Expired`  out  1  level, high in EXPIRED until the next `Load` or reset.

## Operation
- States: IDLE, LOADED, RUNNING, PAUSED, EXPIRED.
- Reset (`Reset_n`=0, asynchronous, any state or mid-count):
  - state=IDLE, `PresentTime`=0, `Busy`=0, `Done`=0, `Expired`=0, prescaler=0.
- Preset = `CounterInput` × `PRESET_STEP`, computed at ≥16 bits.
  - If the product exceeds 4095, saturate to 4095. Never wrap.
- `Load`=1 in any state, taking priority over `CounterEnable`:
  - `PresentTime` ← preset, prescaler ← 0, `Expired` ← 0, `Done` ← 0.
  - Next state is LOADED if preset≠0, otherwise IDLE.
- IDLE: holds and ignores `CounterEnable`.
- LOADED or PAUSED with `CounterEnable`=1 and `Load`=0: go to RUNNING.
  - The prescaler is unchanged on that transition edge.
- RUNNING with `CounterEnable`=1:
  - Prescaler increments each edge.
  - When the prescaler equals `CLK_DIV`−1, it wraps to 0 and `PresentTime` decrements by 1 on the same edge.
- RUNNING with `CounterEnable`=0: go to PAUSED.
  - The prescaler and `PresentTime` hold; the prescaler is NOT cleared.
- Terminal decrement (`PresentTime` 1→0) on edge k:
  - state=EXPIRED, `Expired`=1, `Busy`=0.
  - `Done`=1 for exactly the cycle after edge k.
- EXPIRED: ignores `CounterEnable`; only `Load` or reset leaves it.
- `PresentTime` never decrements below 0 and never underflows to 4095.
- `Done` is never asserted by `Load`, by reset, or by a zero preset.

## Timing
- `Load` sampled at edge k: `PresentTime` and state are valid after edge k (1-cycle latency).
- Counting sequence, with prescaler=0 and `CounterEnable` held high from LOADED:
  - edge k enters RUNNING;
  - first decrement at edge k+`CLK_DIV`;
  - subsequent decrements every `CLK_DIV` edges.
- `CLK_DIV`=1: one decrement per enabled edge in RUNNING.
- Pause/resume: after resuming at edge r (PAUSED→RUNNING), the next decrement comes `CLK_DIV`−p edges after r.
  - p is the prescaler value held while paused.
- Full-countdown duration from the RUNNING entry edge: preset×`CLK_DIV` edges, assuming continuous enable.
- `Busy` goes low on the same edge that enters PAUSED or EXPIRED.
- `Load` and `CounterEnable` both high: the load wins and the state becomes LOADED. RUNNING resumes on the next edge if enable stays high.
- `Load` on the same edge as the terminal decrement: the load wins, with no `Done` and no `Expired`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
All scenarios use `CLK_DIV`=4 and `PRESET_STEP`=60 unless stated.
- **Load:** reset, then `Load` with code 2 → `PresentTime`=120 and state LOADED one cycle later, with `Busy`=0, `Done`=0, `Expired`=0.
- **Full countdown:** code 1 load, then `CounterEnable` held high → `PresentTime`=59 four edges after RUNNING entry. It reaches 0 at 240 edges, with a single-cycle `Done`, `Expired`=1 and `Busy`=0. It stays at 0 for 20 further cycles.
- **Pause/resume:** code 1 load, run until prescaler=2, drop enable for 10 cycles → `PresentTime` and `Busy`=0 hold. Re-enable → the next decrement is 2 edges after the resume edge.
- **Load priority:** while RUNNING at 100, assert `Load` with code 3 and enable together → `PresentTime`=180, state LOADED, then RUNNING on the next edge. A load coinciding with the 1→0 decrement gives no `Done`.
- **Zero and saturation:** code 0 load → IDLE, `PresentTime`=0, and enable is ignored with no `Done`. With `PRESET_STEP`=300, code 15 → `PresentTime`=4095.
- **Reset mid-run:** `Reset_n` low between clock edges while RUNNING at 57 → all outputs 0 immediately (asynchronously). After release, enable alone does not start counting.
